commit_bus_arbiter: RTL and testbench
=====================================

// Module: commit_bus_arbiter
// PURPOSE
//  Arbitrates the shared commit bus among NUM_RS reservation stations (adder, multiplier, assign, ...).
//  Each station raises a commit request with its packet: {RSID, WE, DST, X, Y, Z}.
//  The arbiter picks one winner per cycle (round-robin) and returns a one-cycle grant pulse.
//  It registers the winning packet onto the broadcast commit bus read by the register file and all stations.
// PARAMETERS
//  NUM_RS  4                     number of requesting reservation stations (2..8)
//  PKT_W   `COMMIT_PACKET_SIZE   commit packet width
// PORTS
//  Clock           in   1            single clock, rising edge
//  Reset           in   1            synchronous, active-low
//  iCommitRequest  in   NUM_RS       bit k = station k holds a result
//  iCommitData     in   NUM_RS*PKT_W station k packet at [k*PKT_W +: PKT_W]
//  iStall          in   1            register file cannot accept a commit this cycle
//  oCommitGranted  out  NUM_RS       one-hot grant pulse, registered
//  oCommitBus      out  PKT_W        registered winning packet
//  oCommitValid    out  1            oCommitBus holds a new commit this cycle
// BEHAVIOUR
//  - Reset low at an edge: all outputs 0; round-robin pointer = 0.
//    Reset mid-transfer drops the pending grant; no partial commit is emitted.
//  - Eligible set at cycle N = iCommitRequest & ~mask, where mask = oCommitGranted as registered in cycle N.
//    This hides a station's stale request in the cycle its grant is visible.
//  - iStall=1 or eligible==0 at the cycle-N edge: at N+1, oCommitGranted=0 and oCommitValid=0.
//    oCommitBus holds its previous value. The pointer does not move.
//  - Otherwise the winner k is the first eligible station at or after the pointer, wrapping modulo NUM_RS.
//    At N+1: oCommitGranted=1<<k, oCommitValid=1, oCommitBus=packet k sampled at edge N.
//    The pointer becomes (k+1) mod NUM_RS.
//  - Latency: request to grant/bus = 1 cycle. At most one commit per cycle; back-to-back commits from
//    different stations are allowed.
//  - A station must hold its request and packet stable until it sees its grant. It drops both the
//    cycle after the grant.
//  - Simultaneous requests: fairness is guaranteed. Any station that keeps requesting is granted
//    within NUM_RS non-stalled cycles.
//  - A single requester k that re-requests right after a grant is granted every other cycle, because
//    of the mask.
//  - Packet is passed through unmodified; no width conversion.
// CONFIGURATION
//  COMMIT_ARB_STATS_EN defined:
//    Adds output oCommitCount[31:0], which increments on every oCommitValid=1 cycle.
//    Adds output oConflictCount[31:0], which increments each arbitration cycle with >=2 eligible
//    requesters and iStall=0.
//    Both counters saturate at 32'hFFFF_FFFF and clear on reset.
//  COMMIT_ARB_STATS_EN undefined: these ports and counters do not exist. Grant behaviour is identical.
// STRUCTURE
//  - Shared definitions (aDefinitions.v): COMMIT_PACKET_SIZE and the COMMIT_RSID/WE/DST and X/Y/Z
//    field ranges. RS id encodings are also defined there.
//  - Sub-module rr_priority_picker (NUM_RS):
//    in: request vector, pointer. out: one-hot winner, found flag, next pointer. Purely combinational.
//  - Top level: mask register, pointer register, output registers, optional stats counters.
//  - Flops use the codebase's synchronous-reset flop cells with active-low reset.
// TESTING
//  1. Reset held low 3 cycles with all requests=1:
//     grants/valid/bus = 0. Release: first grant goes to station 0.
//  2. Single request on station 2 with DST=5, X=Y=Z=32'h3F80_0000:
//     next cycle oCommitGranted=4'b0100, oCommitValid=1, oCommitBus=that packet.
//  3. Request vector 4'b1111 held constantly:
//     grants follow the order 0001, 0010, 0100, 1000, 0001. oCommitValid stays 1 every cycle.
//  4. Station 1 requests continuously alone:
//     grant 0010, then 0000, then 0010 (mask prevents a double grant).
//  5. iStall=1 for 4 cycles with requests 4'b1010:
//     no grants, bus holds. Release: grant 0010, then 1000.
//  6. Reset asserted the cycle after a request was sampled:
//     grant and valid read 0 next cycle, and the pointer returns to 0.
//     With COMMIT_ARB_STATS_EN, after test 3 (8 cycles) oCommitCount=8 and oConflictCount=8.

Source files
------------

// File: rtl/commit_bus_arbiter_pkg.sv
// Shared commit-bus definitions: packet layout, field ranges and RS id encodings.
package commit_bus_arbiter_pkg;

    localparam int RSID_W = 4;
    localparam int DST_W  = 8;
    localparam int DATA_W = 32;

    localparam int COMMIT_PACKET_SIZE = RSID_W + 1 + DST_W + 3 * DATA_W;

    // Field ranges within a packet laid out as {RSID, WE, DST, X, Y, Z}, Z at bit 0
    localparam int COMMIT_Z_LSB    = 0;
    localparam int COMMIT_Z_MSB    = COMMIT_Z_LSB + DATA_W - 1;
    localparam int COMMIT_Y_LSB    = COMMIT_Z_MSB + 1;
    localparam int COMMIT_Y_MSB    = COMMIT_Y_LSB + DATA_W - 1;
    localparam int COMMIT_X_LSB    = COMMIT_Y_MSB + 1;
    localparam int COMMIT_X_MSB    = COMMIT_X_LSB + DATA_W - 1;
    localparam int COMMIT_DST_LSB  = COMMIT_X_MSB + 1;
    localparam int COMMIT_DST_MSB  = COMMIT_DST_LSB + DST_W - 1;
    localparam int COMMIT_WE       = COMMIT_DST_MSB + 1;
    localparam int COMMIT_RSID_LSB = COMMIT_WE + 1;
    localparam int COMMIT_RSID_MSB = COMMIT_RSID_LSB + RSID_W - 1;

    typedef enum logic [RSID_W-1:0] {
        RS_ADDER  = 4'd0,
        RS_MULT   = 4'd1,
        RS_ASSIGN = 4'd2,
        RS_DIV    = 4'd3
    } rs_id_e;

    typedef struct packed {
        logic [RSID_W-1:0] rsid;
        logic              we;
        logic [DST_W-1:0]  dst;
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
        logic [DATA_W-1:0] z;
    } commit_pkt_t;

    function automatic commit_pkt_t make_pkt(input logic [RSID_W-1:0] rsid, input logic we,
                                             input logic [DST_W-1:0] dst, input logic [DATA_W-1:0] x,
                                             input logic [DATA_W-1:0] y, input logic [DATA_W-1:0] z);
        commit_pkt_t p;
        p.rsid = rsid;
        p.we   = we;
        p.dst  = dst;
        p.x    = x;
        p.y    = y;
        p.z    = z;
        return p;
    endfunction

    function automatic int wrap_add(input int a, input int b, input int n);
        return (a + b) % n;
    endfunction

endpackage

// File: rtl/commit_bus_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_priority_picker
    import commit_bus_arbiter_pkg::*;
#(
    parameter int NUM_RS = 4,
    parameter int PTR_W  = (NUM_RS > 1) ? $clog2(NUM_RS) : 1
) (
    input  logic [NUM_RS-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NUM_RS-1:0] grant,
    output logic              found,
    output logic [PTR_W-1:0]  next_ptr
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        grant    = '0;
        found    = 1'b0;
        next_ptr = ptr;
        idx      = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            idx = PTR_W'(wrap_add(int'(ptr), i, NUM_RS));
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                next_ptr   = PTR_W'(wrap_add(int'(idx), 1, NUM_RS));
            end
        end
    end

endmodule

// File: rtl/commit_bus_arbiter.sv
// Round-robin commit bus arbiter with registered grant and broadcast packet.
// Optional saturating commit/conflict counters when COMMIT_ARB_STATS_EN is defined.
module commit_bus_arbiter
    import commit_bus_arbiter_pkg::*;
#(
    parameter int NUM_RS = 4,
    parameter int PKT_W  = COMMIT_PACKET_SIZE
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic [NUM_RS-1:0]       iCommitRequest,
    input  logic [NUM_RS*PKT_W-1:0] iCommitData,
    input  logic                    iStall,
    output logic [NUM_RS-1:0]       oCommitGranted,
    output logic [PKT_W-1:0]        oCommitBus,
    output logic                    oCommitValid
`ifdef COMMIT_ARB_STATS_EN
    ,
    output logic [31:0]             oCommitCount,
    output logic [31:0]             oConflictCount
`endif
);

    localparam int PTR_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  next_ptr;
    logic [NUM_RS-1:0] eligible;
    logic [NUM_RS-1:0] winner;
    logic              found;
    logic [PKT_W-1:0]  win_pkt;
    logic              commit;

    // The registered grant doubles as the mask so a stale request is not re-granted
    assign eligible = iCommitRequest & ~oCommitGranted;
    assign commit   = found && !iStall;

    rr_priority_picker #(.NUM_RS(NUM_RS), .PTR_W(PTR_W)) u_picker (
        .req      (eligible),
        .ptr      (ptr),
        .grant    (winner),
        .found    (found),
        .next_ptr (next_ptr)
    );

    always_comb begin
        win_pkt = '0;
        for (int k = 0; k < NUM_RS; k++) begin
            if (winner[k]) win_pkt = win_pkt | iCommitData[k*PKT_W +: PKT_W];
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            ptr            <= '0;
            oCommitGranted <= '0;
            oCommitValid   <= 1'b0;
            oCommitBus     <= '0;
        end else if (commit) begin
            ptr            <= next_ptr;
            oCommitGranted <= winner;
            oCommitValid   <= 1'b1;
            oCommitBus     <= win_pkt;
        end else begin
            oCommitGranted <= '0;
            oCommitValid   <= 1'b0;
        end
    end

`ifdef COMMIT_ARB_STATS_EN
    logic conflict;
    assign conflict = ($countones(eligible) > 1) && !iStall;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            oCommitCount   <= '0;
            oConflictCount <= '0;
        end else begin
            if (commit && oCommitCount != 32'hFFFF_FFFF) oCommitCount <= oCommitCount + 32'd1;
            if (conflict && oConflictCount != 32'hFFFF_FFFF) oConflictCount <= oConflictCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_commit_bus_arbiter.sv
// Directed bench for commit_bus_arbiter with hand-computed grant/bus expectations.
module tb_commit_bus_arbiter;
    import commit_bus_arbiter_pkg::*;

    localparam int NUM_RS = 4;
    localparam int PKT_W  = COMMIT_PACKET_SIZE;

    logic                    Clock = 1'b0;
    logic                    Reset;
    logic [NUM_RS-1:0]       iCommitRequest;
    logic [NUM_RS*PKT_W-1:0] iCommitData;
    logic                    iStall;
    logic [NUM_RS-1:0]       oCommitGranted;
    logic [PKT_W-1:0]        oCommitBus;
    logic                    oCommitValid;
`ifdef COMMIT_ARB_STATS_EN
    logic [31:0]             oCommitCount;
    logic [31:0]             oConflictCount;
`endif

    logic [PKT_W-1:0] pkt [NUM_RS];
    int vectors = 0;
    int errs    = 0;

    commit_bus_arbiter #(.NUM_RS(NUM_RS), .PKT_W(PKT_W)) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .iCommitRequest (iCommitRequest),
        .iCommitData    (iCommitData),
        .iStall         (iStall),
        .oCommitGranted (oCommitGranted),
        .oCommitBus     (oCommitBus),
        .oCommitValid   (oCommitValid)
`ifdef COMMIT_ARB_STATS_EN
        ,
        .oCommitCount   (oCommitCount),
        .oConflictCount (oConflictCount)
`endif
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_data();
        for (int k = 0; k < NUM_RS; k++) iCommitData[k*PKT_W +: PKT_W] = pkt[k];
    endtask

    task automatic chk_out(input string tag, input logic [NUM_RS-1:0] g, input logic v,
                           input logic [PKT_W-1:0] b);
        chk({tag, "_gnt"}, 128'(oCommitGranted), 128'(g));
        chk({tag, "_vld"}, 128'(oCommitValid), 128'(v));
        chk({tag, "_bus"}, 128'(oCommitBus), 128'(b));
    endtask

    initial begin
        for (int k = 0; k < NUM_RS; k++)
            pkt[k] = make_pkt(RSID_W'(k), 1'b1, DST_W'(k + 8), 32'hA000_0000 + k,
                              32'hB000_0000 + k, 32'hC000_0000 + k);
        drive_data();
        Reset          = 1'b0;
        iStall         = 1'b0;
        iCommitRequest = 4'b1111;

        // Reset held with all stations requesting
        repeat (3) begin
            tick();
            chk_out("reset", 4'b0000, 1'b0, '0);
        end
        Reset = 1'b1;

        // Constant full request: rotation starting at station 0
        tick();
        chk_out("first", 4'b0001, 1'b1, pkt[0]);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("rotate", NUM_RS'(1 << ((i + 1) % 4)), 1'b1, pkt[(i + 1) % 4]);
        end
`ifdef COMMIT_ARB_STATS_EN
        chk("commit_count", 128'(oCommitCount), 128'd5);
        chk("conflict_count", 128'(oConflictCount), 128'd5);
`endif

        // Single request from station 2 carrying DST=5, X=Y=Z=1.0f
        pkt[2] = make_pkt(4'd2, 1'b1, 8'd5, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
        drive_data();
        iCommitRequest = 4'b0100;
        tick();
        chk_out("single", 4'b0100, 1'b1, pkt[2]);
        iCommitRequest = 4'b0000;
        tick();
        chk_out("idle_hold", 4'b0000, 1'b0, pkt[2]);

        // Lone continuous requester is granted every other cycle
        iCommitRequest = 4'b0010;
        tick();
        chk_out("lone_a", 4'b0010, 1'b1, pkt[1]);
        tick();
        chk_out("lone_mask", 4'b0000, 1'b0, pkt[1]);
        tick();
        chk_out("lone_b", 4'b0010, 1'b1, pkt[1]);

        // Move pointer to 3, then reset while another grant would be pending
        iCommitRequest = 4'b0100;
        tick();
        chk_out("pre_rst", 4'b0100, 1'b1, pkt[2]);
        iCommitRequest = 4'b1010;
        Reset          = 1'b0;
        tick();
        chk_out("mid_rst", 4'b0000, 1'b0, '0);
        Reset  = 1'b1;

        // Stall four cycles, then pointer-0 order picks station 1 before 3
        iStall = 1'b1;
        repeat (4) begin
            tick();
            chk_out("stall", 4'b0000, 1'b0, '0);
        end
        iStall = 1'b0;
        tick();
        chk_out("unstall_a", 4'b0010, 1'b1, pkt[1]);
        iCommitRequest = 4'b1000;
        tick();
        chk_out("unstall_b", 4'b1000, 1'b1, pkt[3]);
        iCommitRequest = 4'b0000;
        tick();
        chk_out("drain", 4'b0000, 1'b0, pkt[3]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
